// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bank arbiter.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  // Requester indices: instruction fetch and data port.
  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_WR3  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module sram_rr_pick
  import sram_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  // Combinational grant decision.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_IF;
    if (req0 && req1) begin
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = PORT_DATA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter and cycle sequencer for one asynchronous SRAM bank shared by the
// instruction-fetch and data ports. All SRAM-facing outputs and acks come
// straight from flops so the strobes are glitch-free.
//
// state   | meaning
// IDLE    | sample requests, latch the winner
// RD1     | ce/oe low, address on the bus
// RD2     | strobes held, read data captured at the closing edge
// WR1     | ce low, address and data driven, we still high
// WR2     | we low
// WR3     | we back high, ce/address/data still held
// DONE    | strobes released, ack to the granted port
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk_mem,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_t,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              sram_ce,
  output logic              sram_oe,
  output logic              sram_we,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_idx_q, gnt_idx_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_data_o_q, sram_data_o_d;
  logic              sram_data_t_q, sram_data_t_d;
  logic              sram_ce_q, sram_ce_d;
  logic              sram_oe_q, sram_oe_d;
  logic              sram_we_q, sram_we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  sram_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Steer the winning port's request fields.
  always_comb begin
    sel_we    = (gnt_idx == PORT_IF) ? we0    : we1;
    sel_addr  = (gnt_idx == PORT_IF) ? addr0  : addr1;
    sel_wdata = (gnt_idx == PORT_IF) ? wdata0 : wdata1;
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they appear in that state's cycle.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_idx_d     = gnt_idx_q;
    sram_addr_d   = sram_addr_q;
    sram_data_o_d = sram_data_o_q;
    sram_data_t_d = sram_data_t_q;
    sram_ce_d     = sram_ce_q;
    sram_oe_d     = sram_oe_q;
    sram_we_d     = sram_we_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata_d       = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          gnt_idx_d     = gnt_idx;
          last_grant_d  = gnt_idx;
          sram_addr_d   = sel_addr;
          sram_data_o_d = sel_wdata;
          sram_ce_d     = 1'b0;
          if (sel_we) begin
            // we stays high here so it never falls together with ce.
            sram_data_t_d = 1'b1;
            state_d       = ST_WR1;
          end else begin
            sram_oe_d = 1'b0;
            state_d   = ST_RD1;
          end
        end
      end
      ST_RD1: begin
        state_d = ST_RD2;
      end
      ST_RD2: begin
        rdata_d   = sram_data_i;
        sram_ce_d = 1'b1;
        sram_oe_d = 1'b1;
        ack0_d    = (gnt_idx_q == PORT_IF);
        ack1_d    = (gnt_idx_q == PORT_DATA);
        state_d   = ST_DONE;
      end
      ST_WR1: begin
        sram_we_d = 1'b0;
        state_d   = ST_WR2;
      end
      ST_WR2: begin
        sram_we_d = 1'b1;
        state_d   = ST_WR3;
      end
      ST_WR3: begin
        sram_ce_d     = 1'b1;
        sram_data_t_d = 1'b0;
        ack0_d        = (gnt_idx_q == PORT_IF);
        ack1_d        = (gnt_idx_q == PORT_DATA);
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        sram_ce_d     = 1'b1;
        sram_oe_d     = 1'b1;
        sram_we_d     = 1'b1;
        sram_data_t_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge clk_mem or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= PORT_DATA;
      gnt_idx_q     <= PORT_IF;
      sram_addr_q   <= '0;
      sram_data_o_q <= '0;
      sram_data_t_q <= 1'b0;
      sram_ce_q     <= 1'b1;
      sram_oe_q     <= 1'b1;
      sram_we_q     <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_idx_q     <= gnt_idx_d;
      sram_addr_q   <= sram_addr_d;
      sram_data_o_q <= sram_data_o_d;
      sram_data_t_q <= sram_data_t_d;
      sram_ce_q     <= sram_ce_d;
      sram_oe_q     <= sram_oe_d;
      sram_we_q     <= sram_we_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata_q       <= rdata_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_data_o = sram_data_o_q;
  assign sram_data_t = sram_data_t_q;
  assign sram_ce     = sram_ce_q;
  assign sram_oe     = sram_oe_q;
  assign sram_we     = sram_we_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: per-port requesters, an SRAM array model, and a
// transaction-level reference that predicts grants, strobe windows, acks
// and read data from the arbitration and timing rules.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } txn_t;

  logic          clk_mem = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_o, sram_data_i;
  logic          sram_data_t, sram_ce, sram_oe, sram_we, busy;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] pool [8];

  int n_cmp, n_mis;
  int cyc;
  // reference: the transaction most recently granted
  bit            act_v;
  int            act_start, act_port;
  bit            act_we;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_data, act_rd;
  int            mlast;

  txn_t txq0[$], txq1[$];
  int   pend0, pend1;

  int ack_ports[$], ack_cycs[$];
  int ce_low_n, oe_low_n, we_low_n, t_hi_n;

  always #10 clk_mem = ~clk_mem;

  assign sram_data_i = (!sram_ce && !sram_oe) ? sram_mem[sram_addr] : '0;

  sram_arbiter dut (
    .clk_mem     (clk_mem),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata       (rdata),
    .sram_addr   (sram_addr),
    .sram_data_o (sram_data_o),
    .sram_data_t (sram_data_t),
    .sram_data_i (sram_data_i),
    .sram_ce     (sram_ce),
    .sram_oe     (sram_oe),
    .sram_we     (sram_we),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // cyc counts clock edges; the cycle following edge n has cyc == n. A
  // request sampled at edge E is therefore acked in cycle E+2 (read) or
  // E+3 (write) in this numbering, and the next sampling edge is E+4 / E+5.
  function automatic int lat_of(input bit w);
    return w ? 3 : 2;
  endfunction

  function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int g);
    txn_t t;
    t.we = w; t.addr = a; t.data = d; t.gap = g;
    return t;
  endfunction

  task automatic push(input int p, input txn_t t);
    if (p == 0) begin txq0.push_back(t); pend0++; end
    else        begin txq1.push_back(t); pend1++; end
  endtask

  task automatic drive(input int p, input logic r, input txn_t t);
    if (p == 0) begin req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.data; end
    else        begin req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.data; end
  endtask

  task automatic requester(input int p);
    txn_t t;
    bit   ok, aborted, a;
    forever begin
      if ((p == 0 ? txq0.size() : txq1.size()) == 0) begin
        @(posedge clk_mem); #1;
        continue;
      end
      t = (p == 0) ? txq0.pop_front() : txq1.pop_front();
      if (t.gap > 0) begin
        repeat (t.gap) @(posedge clk_mem);
        #1;
      end
      drive(p, 1'b1, t);
      ok = 0; aborted = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk_mem);
        a = (p == 0) ? ack0 : ack1;
        if (rst) begin aborted = 1; break; end
        if (a) begin ok = 1; break; end
      end
      if (!aborted) chk($sformatf("ack_seen_p%0d", p), ok, 1'b1);
      @(posedge clk_mem); #1;
      drive(p, 1'b0, t);
      if (p == 0) pend0--; else pend1--;
    end
  endtask

  task automatic model_loop();
    int p;
    forever begin
      @(posedge clk_mem);
      cyc++;
      if (rst) begin
        act_v = 0;
        mlast = 1;
      end else if (!act_v || (cyc - act_start) > lat_of(act_we) + 1) begin
        if (req0 || req1) begin
          if (req0 && req1) p = 1 - mlast;
          else              p = req0 ? 0 : 1;
          mlast     = p;
          act_v     = 1;
          act_start = cyc;
          act_port  = p;
          act_we    = (p == 0) ? we0 : we1;
          act_addr  = (p == 0) ? addr0 : addr1;
          act_data  = (p == 0) ? wdata0 : wdata1;
          if (act_we) ref_mem[act_addr] = act_data;
          else        act_rd = ref_mem.exists(act_addr) ? ref_mem[act_addr] : '0;
        end
      end
    end
  endtask

  task automatic monitor();
    int         k;
    logic [3:0] s_exp;
    logic [1:0] a_exp;
    logic       b_exp, ce_exp_low, t_exp;
    forever begin
      @(negedge clk_mem);
      k = cyc - act_start;
      s_exp = 4'b1110;
      a_exp = 2'b00;
      b_exp = 1'b0;
      if (act_v) begin
        if (act_we && k >= 0 && k <= 2) s_exp = {1'b0, 1'b1, (k == 1) ? 1'b0 : 1'b1, 1'b1};
        if (!act_we && k >= 0 && k <= 1) s_exp = 4'b0010;
        if (k == lat_of(act_we)) a_exp = (act_port == 0) ? 2'b01 : 2'b10;
        b_exp = (k >= 0 && k <= lat_of(act_we));
      end
      ce_exp_low = ~s_exp[3];
      t_exp      = s_exp[0];
      chk("strobes", {sram_ce, sram_oe, sram_we, sram_data_t}, s_exp);
      chk("ack", {ack1, ack0}, a_exp);
      chk("busy", busy, b_exp);
      if (ce_exp_low) chk("sram_addr", sram_addr, act_addr);
      if (t_exp) chk("sram_data_o", sram_data_o, act_data);
      if (a_exp != 2'b00 && !act_we) chk("rdata", rdata, act_rd);
      if (ack0) begin ack_ports.push_back(0); ack_cycs.push_back(cyc); end
      if (ack1) begin ack_ports.push_back(1); ack_cycs.push_back(cyc); end
      if (!sram_ce) ce_low_n++;
      if (!sram_oe) oe_low_n++;
      if (!sram_we) we_low_n++;
      if (sram_data_t) t_hi_n++;
    end
  endtask

  task automatic sram_writer();
    forever begin
      @(posedge sram_we);
      if (!sram_ce) sram_mem[sram_addr] = sram_data_o;
    end
  endtask

  task automatic clear_obs();
    ack_ports.delete();
    ack_cycs.delete();
    ce_low_n = 0; oe_low_n = 0; we_low_n = 0; t_hi_n = 0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_mem);
      if (pend0 == 0 && pend1 == 0) begin done = 1; break; end
    end
    chk("drain", done, 1'b1);
    repeat (3) @(negedge clk_mem);
  endtask

  initial begin
    bit   found;
    txn_t t;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    n_cmp = 0; n_mis = 0; cyc = 0;
    act_v = 0; act_start = 0; act_port = 0; act_we = 0;
    act_addr = '0; act_data = '0; act_rd = '0; mlast = 1;
    pend0 = 0; pend1 = 0;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'($urandom_range(32'h00100, 32'hFFFF0));
      sram_mem[pool[i]] = $urandom;
      ref_mem[pool[i]]  = sram_mem[pool[i]];
    end
    sram_mem[20'h00010] = 32'hDEADBEEF;
    ref_mem[20'h00010]  = 32'hDEADBEEF;

    fork
      model_loop();
      monitor();
      sram_writer();
      requester(0);
      requester(1);
    join_none

    // reset values
    repeat (3) @(negedge clk_mem);
    chk("rst_strobes", {sram_ce, sram_oe, sram_we, sram_data_t}, 4'b1110);
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_data_o", sram_data_o, 32'h0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk_mem); #1;
    rst = 1'b0;

    // single read on port 0
    @(negedge clk_mem);
    clear_obs();
    push(0, mk(1'b0, 20'h00010, 32'h0, 0));
    wait_drain();
    chk("rd_ack_count", ack_ports.size(), 1);
    chk("rd_ack_port", ack_ports[0], 0);
    chk("rd_rdata_hold", rdata, 32'hDEADBEEF);
    chk("rd_ce_cycles", ce_low_n, 2);
    chk("rd_oe_cycles", oe_low_n, 2);
    chk("rd_t_cycles", t_hi_n, 0);

    // single write on port 1
    clear_obs();
    push(1, mk(1'b1, 20'hFFFFF, 32'h12345678, 0));
    wait_drain();
    chk("wr_ack_port", ack_ports[0], 1);
    chk("wr_we_cycles", we_low_n, 1);
    chk("wr_ce_cycles", ce_low_n, 3);
    chk("wr_oe_cycles", oe_low_n, 0);
    chk("wr_mem", sram_mem[20'hFFFFF], 32'h12345678);

    // contention: both ports held for four transactions
    clear_obs();
    push(0, mk(1'b0, pool[0], 32'h0, 0));
    push(1, mk(1'b1, pool[2], 32'hCAFE0002, 0));
    push(0, mk(1'b1, pool[1], 32'hCAFE0001, 0));
    push(1, mk(1'b0, pool[1], 32'h0, 0));
    wait_drain();
    chk("cont_count", ack_ports.size(), 4);
    for (int i = 0; i < 4 && i < ack_ports.size(); i++)
      chk($sformatf("cont_order%0d", i), ack_ports[i], i % 2);
    chk("cont_rd_back", rdata, 32'hCAFE0001);

    // late request raised during RD2 of a port-0 read
    clear_obs();
    push(0, mk(1'b0, pool[3], 32'h0, 0));
    push(1, mk(1'b0, pool[2], 32'h0, 2));
    wait_drain();
    chk("late_count", ack_ports.size(), 2);
    if (ack_ports.size() == 2) begin
      chk("late_first", ack_ports[0], 0);
      chk("late_second", ack_ports[1], 1);
    end
    chk("late_rdata", rdata, 32'hCAFE0002);

    // req0 held through the idle cycle: a second back-to-back read
    clear_obs();
    push(0, mk(1'b0, pool[4], 32'h0, 0));
    push(0, mk(1'b0, pool[4], 32'h0, 0));
    wait_drain();
    chk("held_count", ack_ports.size(), 2);
    if (ack_cycs.size() == 2) chk("held_ack_gap", ack_cycs[1] - ack_cycs[0], 4);

    // reset during WR2
    clear_obs();
    push(1, mk(1'b1, 20'h00007, 32'hA5A55A5A, 0));
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_mem);
      if (act_v && act_we && (cyc - act_start) == 1) begin found = 1; break; end
    end
    chk("rst_reach_wr2", found, 1'b1);
    chk("wr2_we_low", sram_we, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_strobes", {sram_ce, sram_oe, sram_we, sram_data_t}, 4'b1110);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_addr", sram_addr, 20'h0);
    @(posedge clk_mem);
    @(posedge clk_mem); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk_mem);
    chk("rst_no_ack", ack_ports.size(), 0);

    // tie right after reset: port 0 first
    clear_obs();
    push(0, mk(1'b0, pool[5], 32'h0, 0));
    push(1, mk(1'b0, pool[6], 32'h0, 0));
    wait_drain();
    chk("tie_count", ack_ports.size(), 2);
    if (ack_ports.size() == 2) begin
      chk("tie_first", ack_ports[0], 0);
      chk("tie_second", ack_ports[1], 1);
    end

    // random traffic on both ports
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++) begin
        t = mk(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom, int'($urandom_range(0, 3)));
        push(p, t);
      end
    end
    wait_drain();
    for (int i = 0; i < 8; i++) push(0, mk(1'b0, pool[i], 32'h0, 0));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for one asynchronous 32-bit SRAM bank (baseram or extram) on the `clk_mem` domain. The CPU instruction-fetch port (port 0) and data port (port 1) share the bank. The block grants one transaction at a time by round-robin and drives the active-low `ce`/`oe`/`we` strobes with fixed, glitch-free registered timing. One instance is placed per bank; the top level builds the tristate from the split data ports.

## Interface
- `ADDR_W`, 20, SRAM word-address width
- `DATA_W`, 32, SRAM data width
- `clk_mem` in 1: memory clock, 50 MHz; all logic is clocked on the rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req0`, `req1` in 1: transaction request; held high until the matching ack
- `we0`, `we1` in 1: 1 = write, 0 = read; stable while req is high
- `addr0`, `addr1` in ADDR_W: word address
- `wdata0`, `wdata1` in DATA_W: write data
- `ack0`, `ack1` out 1: one-cycle completion pulse
- `rdata` out DATA_W: read data, valid while the read's ack is high
- `sram_addr` out ADDR_W: SRAM address
- `sram_data_o` out DATA_W: data driven to the SRAM
- `sram_data_t` out 1: 1 = drive `sram_data_o` onto the bus
- `sram_data_i` in DATA_W: bus data from the SRAM
- `sram_ce`, `sram_oe`, `sram_we` out 1: active-low chip, output and write enables
- `busy` out 1: high in every state except IDLE

## Operation
- FSM states: IDLE, RD1, RD2, WR1, WR2, WR3, DONE. All SRAM-facing outputs and `ack*` are registered.
- **IDLE**
  - `req*` is sampled only in IDLE.
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time wins; `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant, latch the port's addr, wdata and we plus a grant index, and update `last_grant`.
  - Go to RD1 if we=0, else WR1. With no request, stay in IDLE.
- **RD1**: `sram_ce`=0, `sram_oe`=0, address driven. Go to RD2.
- **RD2**: strobes unchanged. At the closing edge, sample `sram_data_i` into `rdata`. Go to DONE.
- **WR1**: `sram_ce`=0, `sram_we`=1, `sram_data_t`=1, address and data driven. Go to WR2.
- **WR2**: `sram_we`=0. Go to WR3.
- **WR3**: `sram_we`=1; ce, address and data are still held. Go to DONE.
- **DONE**
  - `sram_ce`=`sram_oe`=`sram_we`=1, `sram_data_t`=0.
  - `ack` of the granted port = 1.
  - Go to IDLE.
- The `rdata` register keeps its last value. It is meaningful only during a read ack.
- Address and data are stable for the whole transaction, from before the strobe asserts until after it deasserts. `sram_we` never falls in the same cycle that ce falls.

## Timing
- Reset values: `sram_ce`=`sram_oe`=`sram_we`=1, `sram_data_t`=0, `ack0`=`ack1`=0, `rdata`=0, `sram_addr`=0, `sram_data_o`=0, `busy`=0, state IDLE, `last_grant`=1.
- Read latency: req sampled at edge E makes ack high in cycle E+3. Occupancy is 4 cycles including IDLE.
- Write latency: req sampled at edge E makes ack high in cycle E+4. Occupancy is 5 cycles.
- The requester must drop `req` at the edge ending its ack cycle. If `req` is still high in the following IDLE, it is treated as a new transaction.
- Back-to-back requests: the grant after DONE is re-arbitrated, so with both ports requesting continuously the ports alternate.
- `req` arriving while busy is not sampled until IDLE, and there is no loss as long as it is held.
- A reset asserted mid-transaction forces the reset values immediately: strobes go high and the bus is released. The in-flight transaction gets no ack.
- `req*` changing in non-IDLE states has no effect.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum
  - port index constants `PORT_IF`=0 and `PORT_DATA`=1
  - default `ADDR_W`/`DATA_W`
- One sub-module, `sram_rr_pick`, is natural:
  - inputs `req0`, `req1`, `last_grant`
  - outputs `gnt_valid`, `gnt_idx`
  - purely combinational
- The remainder is the FSM plus the latched-request registers.

## Test plan
- Single read:
  - Stimulus: `req0`=1, `we0`=0, `addr0`=0x00010; SRAM model returns 0xDEADBEEF.
  - Required: `ack0` 3 cycles after sampling, `rdata`=0xDEADBEEF; `sram_oe`/`sram_ce` low for exactly 2 cycles; `sram_data_t` stays 0.
- Single write:
  - Stimulus: `req1`=1, `we1`=1, `addr1`=0xFFFFF, `wdata1`=0x12345678.
  - Required: `sram_we` low for exactly 1 cycle, bracketed by ce-low cycles; the model holds 0x12345678 at 0xFFFFF; `ack1` 4 cycles after sampling.
- Contention:
  - Stimulus: `req0` and `req1` are both held high for 4 transactions.
  - Required: grant order is 0, 1, 0, 1 with one ack per transaction and no overlapping strobes.
- Late request:
  - Stimulus: raise `req1` during RD2 of a port-0 read.
  - Required: port 1 is granted in the IDLE after DONE, and `ack1` arrives later with correct data.
- Reset during WR2:
  - Stimulus: assert `rst` while in WR2.
  - Required: `sram_we`/`sram_ce` go to 1 and `sram_data_t` goes to 0 without waiting for a clock edge; no ack; the next request after reset is served normally with port 0 winning a tie.
- Held req after ack:
  - Stimulus: the requester keeps `req0` high one cycle past its ack.
  - Required: a second transaction starts, and `busy` is 1 continuously except for the single IDLE cycle.
